// File: rtl/fast_square_bb_deframer.sv
// Receive-side deframer for the fast-square baseband stream: finds header + marker-run
// framing, releases payload one word late, and reports frame boundaries and errors.
module fast_square_bb_deframer #(
  parameter int MARKER_LEN = 101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_strobe,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  output logic        out_strobe,
  output logic [15:0] i_out,
  output logic [15:0] q_out,
  output logic        frame_start,
  output logic [31:0] frame_count,
  output logic        seq_err,
  output logic        marker_err,
  output logic        locked,
  output logic [2:0]  mod_index,
  output logic [15:0] payload_count
);

  typedef enum logic [1:0] {HUNT, RUN, PAYLOAD} state_t;

  localparam logic [7:0]  RUN_LEN   = 8'(MARKER_LEN);
  localparam logic [7:0]  RUN_MAX   = 8'(MARKER_LEN + 1);
  localparam logic [15:0] MARKER_HW = 16'h8000;

  state_t      state, state_next;
  logic [31:0] word_in;
  logic [31:0] hold, cand, prev_count;
  logic        hold_v;
  logic [7:0]  run_cnt;
  logic        is_marker;
  logic        accept, reject, emit, load_word, start_run, bump_run;

  function automatic logic [7:0] run_inc_sat(input logic [7:0] v);
    return (v == RUN_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] cnt_inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] mod5_next(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  assign word_in   = {q_in, i_in};
  assign is_marker = (i_in == MARKER_HW) && (q_in == MARKER_HW);

  always_ff @(posedge clock) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (in_strobe) begin
      case (state)
        HUNT:    if (is_marker && hold_v) state_next = RUN;
        RUN:     if (!is_marker) state_next = (run_cnt == RUN_LEN) ? PAYLOAD : HUNT;
        PAYLOAD: if (is_marker) state_next = RUN;
        default: state_next = HUNT;
      endcase
    end
  end

  // Per-word decisions; every non-marker word lands in the holding register.
  always_comb begin
    accept    = in_strobe && (state == RUN) && !is_marker && (run_cnt == RUN_LEN);
    reject    = in_strobe && (state == RUN) && !is_marker && (run_cnt != RUN_LEN);
    emit      = in_strobe && (state == PAYLOAD) && !is_marker;
    load_word = in_strobe && !is_marker;
    start_run = in_strobe && is_marker && (((state == HUNT) && hold_v) || (state == PAYLOAD));
    bump_run  = in_strobe && is_marker && (state == RUN);
  end

  // Data-only registers: their contents are qualified by hold_v / state.
  always_ff @(posedge clock) begin
    if (load_word) hold <= word_in;
    if (start_run) cand <= hold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_v        <= 1'b0;
      run_cnt       <= 8'd0;
      prev_count    <= 32'd0;
      out_strobe    <= 1'b0;
      i_out         <= 16'd0;
      q_out         <= 16'd0;
      frame_start   <= 1'b0;
      frame_count   <= 32'd0;
      seq_err       <= 1'b0;
      marker_err    <= 1'b0;
      locked        <= 1'b0;
      mod_index     <= 3'd0;
      payload_count <= 16'd0;
    end else begin
      frame_start <= accept;
      seq_err     <= accept && locked && (cand != prev_count + 32'd1);
      marker_err  <= reject;
      out_strobe  <= emit;
      if (load_word) hold_v <= 1'b1;
      if (start_run) begin
        hold_v  <= 1'b0;
        run_cnt <= 8'd1;
      end
      if (bump_run) run_cnt <= run_inc_sat(run_cnt);
      if (accept) begin
        frame_count   <= cand;
        prev_count    <= cand;
        locked        <= 1'b1;
        mod_index     <= mod5_next(mod_index);
        payload_count <= 16'd0;
      end
      if (reject) locked <= 1'b0;
      if (emit) begin
        i_out         <= hold[15:0];
        q_out         <= hold[31:16];
        payload_count <= cnt_inc_sat(payload_count);
      end
    end
  end

endmodule

// File: doc/fast_square_bb_deframer.md
# fast_square_bb_deframer

Receive-side deframer for the fast-square baseband sample stream produced by the comb/decimate chain. It consumes strobed 16-bit I/Q words and recognises the frame structure: a header word carrying a 32-bit reset count, then exactly MARKER_LEN restart markers (I = Q = 16'h8000), then payload. It emits payload samples with a strobe, reports frame boundaries, counts and sequence/marker errors, and tracks the modulo-5 frame index. It sits at the capture end of the link, ahead of the sample buffer and host interface.

## Interface
- MARKER_LEN, 101: required marker-run length; legal range 2..254.
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- in_strobe  in  1  single-cycle pulse, one per input word; back-to-back (every cycle) allowed.
- i_in  in  16  I word, or low half of the header count.
- q_in  in  16  Q word, or high half of the header count.
- out_strobe  out  1  payload sample valid, one-cycle pulse.
- i_out, q_out  out  16 each  payload sample; hold their value between strobes.
- frame_start  out  1  one-cycle pulse when a frame is accepted.
- frame_count  out  32  {q,i} of the accepted header; holds until the next accept.
- seq_err  out  1  one-cycle pulse with frame_start when the count breaks sequence.
- marker_err  out  1  one-cycle pulse when a marker run is rejected.
- locked  out  1  high from the first accept until a marker_err or reset.
- mod_index  out  3  accepted-frame index modulo 5 (0..4).
- payload_count  out  16  payload samples emitted in the current frame; saturates at 16'hFFFF.

## Operation
- A word is a marker when i_in == 16'h8000 and q_in == 16'h8000. Words are evaluated only on in_strobe.
- Internal registers:
  - hold/hold_v: one-word holding register and its valid flag.
  - cand: header candidate.
  - run_cnt: 8-bit marker-run counter, saturating at MARKER_LEN+1.
  - prev_count: last accepted header count.
- **HUNT** (reset state):
  - Non-marker: load hold and set hold_v.
  - Marker with hold_v set: cand <= hold, hold_v <= 0, run_cnt <= 1, go to RUN.
  - Marker with hold_v clear: ignore.
- **RUN**:
  - Marker: increment run_cnt (saturating).
  - Non-marker with run_cnt == MARKER_LEN: accept the frame.
    - Pulse frame_start; frame_count <= {cand_q, cand_i}.
    - Pulse seq_err if locked was already set and the count != prev_count+1 (32-bit wrap).
    - Set prev_count and locked; advance mod_index (4 -> 0); clear payload_count.
    - Load the new word into hold, set hold_v, go to PAYLOAD.
  - Non-marker with any other run_cnt (short or long run): pulse marker_err, clear locked, load the word into hold, set hold_v, go to HUNT. frame_count, mod_index and prev_count are unchanged.
- **PAYLOAD**:
  - Non-marker: emit hold on i_out/q_out with out_strobe, load the new word into hold, increment payload_count.
  - Marker: cand <= hold (this word is never emitted as payload), hold_v <= 0, run_cnt <= 1, go to RUN.
- The last payload word of a frame stays held until the next non-marker word. If that next word is the following header, the held word is emitted as payload and the header is held.
- A payload word equal to the marker value is a protocol violation. It either ends the frame (if it follows a held word) or starts a rejected run.

## Timing
- All outputs are registered and update on the clock edge after the in_strobe edge that causes them.
- Payload latency: the word arriving on in_strobe n is output on the cycle after in_strobe n+1.
- frame_start, seq_err and marker_err are asserted together with the decision on the first non-marker word after the run. No out_strobe occurs in that cycle.
- Reset values:
  - State HUNT; hold_v, run_cnt, prev_count = 0.
  - All outputs 0: out_strobe, i_out, q_out, frame_start, frame_count, seq_err, marker_err, locked, mod_index, payload_count.
- Reset has priority over in_strobe in the same cycle. Reset mid-frame discards hold and cand; the next header must be re-acquired from HUNT.

## Test plan
- Header {q=0,i=5}, 101 markers, payload (1,1),(2,2),(3,3) -> one frame_start, frame_count = 5, seq_err = 0, locked = 1, mod_index = 1. out_strobe fires for (1,1) and (2,2) only; (3,3) is held; payload_count = 2.
- Frame 7, payload (4,4), then frame 8 -> (4,4) is emitted when header 8 arrives, seq_err = 0. Repeat with 7 then 9 -> seq_err pulses with the second frame_start.
- Header then 100 markers then (1,1) -> marker_err, no frame_start, locked = 0, state HUNT. Repeat with 102 markers -> marker_err.
- Five clean sequential frames (counts 0..4) -> mod_index steps 1,2,3,4,0. Count 32'hFFFFFFFF followed by 0 -> no seq_err.
- Reset asserted at marker 50 of a run, then a full clean frame -> no frame_start until the clean frame, which is accepted with seq_err = 0 (locked was cleared).
- in_strobe every cycle with a clean frame and 3 payload words -> identical results, with out_strobe on consecutive cycles.
